// File: rtl/block_dispatcher.sv
// block_dispatcher: dynamic thread-block scheduler between the control register
// and the compute cores. Splits a launch into THREADS_PER_CORE-sized blocks,
// hands each block to the lowest-indexed idle core that has seen a reset cycle,
// retires blocks on core_done and raises done once every block has completed.
// Optional build macro DISPATCH_PERF_EN adds a saturating busy_cycles counter.
module block_dispatcher #(
  parameter int unsigned NUM_CORES        = 2,
  parameter int unsigned THREADS_PER_CORE = 4,
  parameter int unsigned COUNT_BITS       = 8,
  localparam int unsigned TC_BITS         = $clog2(THREADS_PER_CORE) + 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic [COUNT_BITS-1:0]           thread_count,
  output logic                            done,
  output logic [NUM_CORES-1:0]            core_start,
  output logic [NUM_CORES-1:0]            core_reset,
  output logic [NUM_CORES*COUNT_BITS-1:0] core_block_id,
  output logic [NUM_CORES*TC_BITS-1:0]    core_thread_count,
  input  logic [NUM_CORES-1:0]            core_done
`ifdef DISPATCH_PERF_EN
  ,
  output logic [15:0]                     busy_cycles
`endif
);

  localparam int unsigned LOG_TPC = $clog2(THREADS_PER_CORE);
  localparam int unsigned CNT_W   = COUNT_BITS + 1;
  localparam int unsigned WIDE_W  = COUNT_BITS + 1 + LOG_TPC;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                 state;
  logic [COUNT_BITS-1:0]  tc_q;
  logic [CNT_W-1:0]       total_blocks;
  logic [CNT_W-1:0]       dispatched;
  logic [CNT_W-1:0]       retired;
  logic [NUM_CORES-1:0]   slot_running;
  logic [NUM_CORES-1:0]   reset_seen;

  logic [NUM_CORES-1:0]   retire_mask;
  logic [CNT_W-1:0]       retire_cnt;
  logic [NUM_CORES-1:0]   disp_sel;
  logic                   disp_found;
  logic [WIDE_W-1:0]      remaining;
  logic [TC_BITS-1:0]     disp_tc;
  logic [CNT_W-1:0]       launch_blocks;

  // Block count for the launch being sampled, rounded up without overflow
  assign launch_blocks = CNT_W'((CNT_W'(thread_count) + CNT_W'(THREADS_PER_CORE - 1)) >> LOG_TPC);

  // Retire set, lowest free-and-reset slot selection, and size of the next block
  always_comb begin
    retire_mask = slot_running & core_done;
    retire_cnt  = '0;
    disp_sel    = '0;
    disp_found  = 1'b0;
    for (int i = 0; i < NUM_CORES; i++) begin
      retire_cnt = retire_cnt + CNT_W'(retire_mask[i]);
      if (!disp_found && !slot_running[i] && reset_seen[i] && (dispatched < total_blocks)) begin
        disp_sel[i] = 1'b1;
        disp_found  = 1'b1;
      end
    end
    remaining = WIDE_W'(tc_q) - (WIDE_W'(dispatched) << LOG_TPC);
    disp_tc   = (remaining >= WIDE_W'(THREADS_PER_CORE)) ? TC_BITS'(THREADS_PER_CORE)
                                                         : TC_BITS'(remaining);
  end

  // Top FSM with per-slot bookkeeping and registered core-facing outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= IDLE;
      done              <= 1'b0;
      core_start        <= '0;
      core_reset        <= '1;
      core_block_id     <= '0;
      core_thread_count <= '0;
      tc_q              <= '0;
      total_blocks      <= '0;
      dispatched        <= '0;
      retired           <= '0;
      slot_running      <= '0;
      reset_seen        <= '1;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            tc_q         <= thread_count;
            total_blocks <= launch_blocks;
            dispatched   <= '0;
            retired      <= '0;
            state        <= (thread_count == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (retired == total_blocks) begin
            state      <= DONE;
            done       <= 1'b1;
            core_start <= '0;
            core_reset <= '1;
          end else begin
            for (int i = 0; i < NUM_CORES; i++) begin
              if (retire_mask[i]) begin
                core_start[i]   <= 1'b0;
                core_reset[i]   <= 1'b1;
                slot_running[i] <= 1'b0;
                reset_seen[i]   <= 1'b0;
              end else if (disp_sel[i]) begin
                core_start[i]   <= 1'b1;
                core_reset[i]   <= 1'b0;
                slot_running[i] <= 1'b1;
                core_block_id[i*COUNT_BITS +: COUNT_BITS] <= COUNT_BITS'(dispatched);
                core_thread_count[i*TC_BITS +: TC_BITS]   <= disp_tc;
              end else if (!slot_running[i] && !reset_seen[i]) begin
                reset_seen[i]   <= 1'b1;
              end
            end
            retired    <= retired + retire_cnt;
            dispatched <= dispatched + CNT_W'(disp_found);
          end
        end
        DONE: begin
          done       <= 1'b1;
          core_start <= '0;
          core_reset <= '1;
          reset_seen <= '1;
          if (!start) begin
            state <= IDLE;
            done  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DISPATCH_PERF_EN
  // Saturating count of cycles spent in RUN, cleared when a launch is accepted
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_cycles <= '0;
    end else if (state == IDLE && start) begin
      busy_cycles <= '0;
    end else if (state == RUN && busy_cycles != 16'hFFFF) begin
      busy_cycles <= busy_cycles + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_block_dispatcher.sv
// Directed testbench for block_dispatcher (default parameters: 2 cores,
// 4 threads per block, 8-bit counts). Define DISPATCH_PERF_EN to also
// exercise busy_cycles.
module tb_block_dispatcher;

  localparam int unsigned NC  = 2;
  localparam int unsigned CB  = 8;
  localparam int unsigned TCB = 3;

  logic              clk;
  logic              reset;
  logic              start;
  logic [CB-1:0]     thread_count;
  logic              done;
  logic [NC-1:0]     core_start;
  logic [NC-1:0]     core_reset;
  logic [NC*CB-1:0]  core_block_id;
  logic [NC*TCB-1:0] core_thread_count;
  logic [NC-1:0]     core_done;
`ifdef DISPATCH_PERF_EN
  logic [15:0]       busy_cycles;
`endif

  int n_cmp = 0;
  int n_err = 0;

  block_dispatcher dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .thread_count      (thread_count),
    .done              (done),
    .core_start        (core_start),
    .core_reset        (core_reset),
    .core_block_id     (core_block_id),
    .core_thread_count (core_thread_count),
    .core_done         (core_done)
`ifdef DISPATCH_PERF_EN
    ,
    .busy_cycles       (busy_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One active edge, then settle so outputs are sampled away from the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] bid(input int i);
    return 32'(core_block_id[i*CB +: CB]);
  endfunction

  function automatic logic [31:0] ctc(input int i);
    return 32'(core_thread_count[i*TCB +: TCB]);
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_done"},  32'(done),       32'd0);
    check({tag, "_start"}, 32'(core_start), 32'd0);
    check({tag, "_creset"}, 32'(core_reset), 32'd3);
    check({tag, "_bid"},   32'(core_block_id), 32'd0);
    check({tag, "_ctc"},   32'(core_thread_count), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    thread_count = '0;
    core_done = '0;
    #2;
    check_reset_outputs("por");
`ifdef DISPATCH_PERF_EN
    check("por_busy", 32'(busy_cycles), 32'd0);
`endif
    tick();
    tick();
    reset = 1'b0;
    tick();
    check("idle_done", 32'(done), 32'd0);

    // Test 1: 8 threads -> two full blocks, one per core
    thread_count = 8'd8; start = 1'b1;
    tick();                                         // edge N
    check("t1_n_start", 32'(core_start), 32'd0);
    thread_count = 8'd200;                          // ignored outside IDLE
    tick();                                         // N+1
    check("t1_n1_start", 32'(core_start), 32'b01);
    check("t1_n1_creset", 32'(core_reset), 32'b10);
    check("t1_n1_bid0", bid(0), 32'd0);
    check("t1_n1_ctc0", ctc(0), 32'd4);
    tick();                                         // N+2
    check("t1_n2_start", 32'(core_start), 32'b11);
    check("t1_n2_creset", 32'(core_reset), 32'b00);
    check("t1_n2_bid1", bid(1), 32'd1);
    check("t1_n2_ctc1", ctc(1), 32'd4);
    start = 1'b0;                                   // ignored during RUN
    core_done = 2'b01;
    tick();                                         // core0 retires
    check("t1_r0_start", 32'(core_start), 32'b10);
    check("t1_r0_creset", 32'(core_reset), 32'b01);
    check("t1_r0_done", 32'(done), 32'd0);
    core_done = 2'b11;                              // bit0 on a free slot: ignored
    tick();                                         // core1 retires
    check("t1_r1_start", 32'(core_start), 32'b00);
    check("t1_r1_done", 32'(done), 32'd0);
    core_done = 2'b00;
    tick();
    check("t1_done", 32'(done), 32'd1);
    check("t1_done_creset", 32'(core_reset), 32'b11);
    tick();                                         // start=0 -> IDLE
    check("t1_idle_done", 32'(done), 32'd0);

    // Test 2: 10 threads -> 3 blocks, core1 reused for the 2-thread tail
    thread_count = 8'd10; start = 1'b1;
    tick();                                         // N
    tick();                                         // N+1
    check("t2_bid0", bid(0), 32'd0);
    tick();                                         // N+2
    check("t2_bid1", bid(1), 32'd1);
    check("t2_start", 32'(core_start), 32'b11);
    start = 1'b0;
    core_done = 2'b10;
    tick();                                         // M: core1 retires
    check("t2_m_start", 32'(core_start), 32'b01);
    check("t2_m_creset", 32'(core_reset), 32'b10);
    check("t2_m_bid1_hold", bid(1), 32'd1);
    core_done = 2'b00;
    tick();                                         // M+1: reset cycle
    check("t2_m1_start", 32'(core_start), 32'b01);
    check("t2_m1_creset", 32'(core_reset), 32'b10);
    tick();                                         // M+2: re-dispatch
    check("t2_m2_start", 32'(core_start), 32'b11);
    check("t2_m2_creset", 32'(core_reset), 32'b00);
    check("t2_m2_bid1", bid(1), 32'd2);
    check("t2_m2_ctc1", ctc(1), 32'd2);
    check("t2_m2_done", 32'(done), 32'd0);
    core_done = 2'b11;
    tick();                                         // blocks 0 and 2 retire together
    check("t2_r_start", 32'(core_start), 32'b00);
    check("t2_r_done", 32'(done), 32'd0);
    check("t2_r_bid1_hold", bid(1), 32'd2);
    core_done = 2'b00;
    tick();
    check("t2_done", 32'(done), 32'd1);
    tick();
    check("t2_idle_done", 32'(done), 32'd0);

    // Test 3: zero threads -> straight to done, no core activity
    thread_count = 8'd0; start = 1'b1;
    tick();                                         // N
    check("t3_n_start", 32'(core_start), 32'd0);
    tick();                                         // N+1
    check("t3_done", 32'(done), 32'd1);
    check("t3_start", 32'(core_start), 32'd0);
    check("t3_creset", 32'(core_reset), 32'b11);
    start = 1'b0;
    tick();
    check("t3_idle_done", 32'(done), 32'd0);

    // Test 4: simultaneous retirement of both blocks
    thread_count = 8'd8; start = 1'b1;
    tick(); tick(); tick();
    check("t4_start", 32'(core_start), 32'b11);
    start = 1'b0;
    core_done = 2'b11;
    tick();
    check("t4_r_done", 32'(done), 32'd0);
    check("t4_r_creset", 32'(core_reset), 32'b11);
    core_done = 2'b00;
    tick();
    check("t4_done", 32'(done), 32'd1);
    tick();
    check("t4_idle_done", 32'(done), 32'd0);

    // Test 5: asynchronous reset mid-RUN, then a single-block launch
    thread_count = 8'd8; start = 1'b1;
    tick(); tick(); tick();
    check("t5_pre_start", 32'(core_start), 32'b11);
    #2 reset = 1'b1;
    #1;
    check_reset_outputs("t5_rst");
    #1 reset = 1'b0;
    thread_count = 8'd4; start = 1'b1;
    tick();                                         // N
    tick();                                         // N+1
    check("t5_n1_start", 32'(core_start), 32'b01);
    check("t5_n1_bid0", bid(0), 32'd0);
    check("t5_n1_ctc0", ctc(0), 32'd4);
    tick();                                         // N+2: nothing more to dispatch
    check("t5_n2_start", 32'(core_start), 32'b01);
    start = 1'b0;
    core_done = 2'b01;
    tick();
    core_done = 2'b00;
    check("t5_r_done", 32'(done), 32'd0);
    tick();
    check("t5_done", 32'(done), 32'd1);
    tick();
    check("t5_idle_done", 32'(done), 32'd0);

`ifdef DISPATCH_PERF_EN
    // Test 6: exactly 20 cycles in RUN
    thread_count = 8'd8; start = 1'b1;
    tick();                                         // N: counter cleared
    check("t6_clear", 32'(busy_cycles), 32'd0);
    start = 1'b0;
    for (int k = 0; k < 18; k++) tick();            // N+1 .. N+18
    core_done = 2'b11;
    tick();                                         // N+19: retire
    core_done = 2'b00;
    tick();                                         // N+20: DONE
    check("t6_done", 32'(done), 32'd1);
    check("t6_busy", 32'(busy_cycles), 32'd20);
    tick();                                         // IDLE: holds
    check("t6_busy_hold", 32'(busy_cycles), 32'd20);
    start = 1'b1;
    tick();
    check("t6_busy_restart", 32'(busy_cycles), 32'd0);
    start = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
